// File: rtl/myo_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and frame word map for the myo motor board sequencer.
package myo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    WAIT_RX,
    DONE
  } state_t;

  // Receive word positions inside a frame; rx word 0 is the board's dummy.
  localparam int RX_POS_HI = 1;
  localparam int RX_POS_LO = 2;
  localparam int RX_VEL    = 3;
  localparam int RX_CUR    = 4;
  localparam int RX_DISP   = 5;

  localparam int TX_PWM  = 1;
  localparam int TX_CTRL = 2;

  localparam logic [15:0] HEADER_DEFAULT = 16'h8000;

endpackage

// File: rtl/myo_period_timer.sv
`timescale 1ns/1ps
// Free-running period counter that emits a one-cycle auto request every
// PERIOD_CYCLES clocks while enabled.
module myo_period_timer #(
  parameter int PERIOD_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == CNT_W'(PERIOD_CYCLES - 1));

  // Dropping enable restarts the period from zero on the next enable.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/myo_frame_sequencer.sv
`timescale 1ns/1ps
// Frame sequencer feeding the SPI master's parallel write port and collecting
// the full-duplex receive words into atomically published motor status.
module myo_frame_sequencer
  import myo_pkg::*;
#(
  parameter int                DATA_W         = 16,
  parameter int                FRAME_WORDS    = 8,
  parameter int                PERIOD_CYCLES  = 50000,
  parameter int                TIMEOUT_CYCLES = 4096,
  parameter logic [DATA_W-1:0] HEADER         = DATA_W'(HEADER_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                trigger,
  input  logic [DATA_W-1:0]   pwm_ref,
  input  logic [DATA_W-1:0]   ctrl_flags,
  input  logic                di_req_i,
  output logic [DATA_W-1:0]   di_o,
  output logic                wren_o,
  input  logic                wr_ack_i,
  input  logic                do_valid_i,
  input  logic [DATA_W-1:0]   do_i,
  output logic [2*DATA_W-1:0] position,
  output logic [DATA_W-1:0]   velocity,
  output logic [DATA_W-1:0]   current,
  output logic [DATA_W-1:0]   displacement,
  output logic                status_valid,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err,
  output logic [15:0]         frame_count
);

  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state;
  logic [IDX_W-1:0]   tx_idx;
  logic [IDX_W-1:0]   rx_idx;
  logic [DATA_W-1:0]  pwm_lat;
  logic [DATA_W-1:0]  ctrl_lat;
  logic [DATA_W-1:0]  tx_word;
  logic [DATA_W-1:0]  shadow [RX_POS_HI:RX_DISP];
  logic               do_valid_q;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               auto_req;
  logic               start_req;
  logic               rx_edge;
  logic               tmo_hit;

  myo_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (auto_req)
  );

  assign start_req = trigger || auto_req;
  assign rx_edge   = do_valid_i && !do_valid_q;
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tx_word = '0;
    if (tx_idx == '0) begin
      tx_word = HEADER;
    end else if (tx_idx == IDX_W'(TX_PWM)) begin
      tx_word = pwm_lat;
    end else if (tx_idx == IDX_W'(TX_CTRL)) begin
      tx_word = ctrl_lat;
    end
  end

  // Every transition clears tmo_cnt, so it measures time spent in the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_idx       <= '0;
      rx_idx       <= '0;
      pwm_lat      <= '0;
      ctrl_lat     <= '0;
      for (int i = RX_POS_HI; i <= RX_DISP; i++) begin
        shadow[i] <= '0;
      end
      do_valid_q   <= 1'b0;
      tmo_cnt      <= '0;
      di_o         <= '0;
      wren_o       <= 1'b0;
      position     <= '0;
      velocity     <= '0;
      current      <= '0;
      displacement <= '0;
      status_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
      frame_count  <= '0;
    end else begin
      do_valid_q   <= do_valid_i;
      status_valid <= 1'b0;
      overrun      <= start_req && busy;
      tmo_cnt      <= tmo_cnt + 1'b1;

      case (state)
        IDLE: begin
          wren_o  <= 1'b0;
          tmo_cnt <= '0;
          if (start_req) begin
            pwm_lat  <= pwm_ref;
            ctrl_lat <= ctrl_flags;
            tx_idx   <= '0;
            rx_idx   <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (di_req_i) begin
            di_o    <= tx_word;
            wren_o  <= 1'b1;
            tmo_cnt <= '0;
            state   <= WRITE;
          end else if (tmo_hit) begin
            wren_o      <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end
        end

        WRITE: begin
          if (wr_ack_i) begin
            wren_o  <= 1'b0;
            tx_idx  <= tx_idx + 1'b1;
            tmo_cnt <= '0;
            state   <= WAIT_RX;
          end else if (tmo_hit) begin
            wren_o      <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end
        end

        // Word 0 and words past the status block are received but not kept.
        WAIT_RX: begin
          if (rx_edge) begin
            if (rx_idx >= IDX_W'(RX_POS_HI) && rx_idx <= IDX_W'(RX_DISP)) begin
              shadow[rx_idx] <= do_i;
            end
            rx_idx  <= rx_idx + 1'b1;
            tmo_cnt <= '0;
            if (rx_idx == IDX_W'(FRAME_WORDS - 1)) begin
              state <= DONE;
            end else begin
              state <= LOAD;
            end
          end else if (tmo_hit) begin
            wren_o      <= 1'b0;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
            state       <= IDLE;
          end
        end

        DONE: begin
          position     <= {shadow[RX_POS_HI], shadow[RX_POS_LO]};
          velocity     <= shadow[RX_VEL];
          current      <= shadow[RX_CUR];
          displacement <= shadow[RX_DISP];
          status_valid <= 1'b1;
          frame_count  <= frame_count + 1'b1;
          timeout_err  <= 1'b0;
          busy         <= 1'b0;
          tmo_cnt      <= '0;
          state        <= IDLE;
        end

        default: begin
          wren_o  <= 1'b0;
          busy    <= 1'b0;
          tmo_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/myo_frame_sequencer.md
Name: myo_frame_sequencer

Overview:
- Upstream/downstream companion of the SPI master. Turns a periodic or manual frame request into a fixed-length 16-bit word frame for one myo motor board.
- Drives the master's parallel write handshake (di_req / di_i / wren / wr_ack).
- Collects the full-duplex receive words (do_valid / do_o) into shadow registers.
- Publishes decoded motor status atomically once per completed frame, for the HPS-side registers.

Parameters:
- DATA_W, 16, SPI word width. Must match the SPI master's word width.
- FRAME_WORDS, 8, words per frame, minimum 6.
- PERIOD_CYCLES, 50000, clk cycles between automatic frame starts (1 kHz at 50 MHz).
- TIMEOUT_CYCLES, 4096, maximum clk cycles spent waiting in any single handshake state.
- HEADER, 16'h8000, transmit word 0.

Ports:
- clk  in  1  system clock; the same clock drives the SPI master's sclk/pclk.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  periodic mode enable.
- trigger  in  1  single-cycle manual frame request.
- pwm_ref  in  16  signed PWM setpoint, sampled at frame start.
- ctrl_flags  in  16  control word, sampled at frame start.
- di_req_i  in  1  SPI master requests the next tx word.
- di_o  out  16  tx word to the SPI master.
- wren_o  out  1  tx word valid / write enable.
- wr_ack_i  in  1  SPI master accepted the tx word.
- do_valid_i  in  1  rx word valid (level from the SPI master).
- do_i  in  16  rx word.
- position  out  32  {rx1, rx2}.
- velocity  out  16  rx3.
- current  out  16  rx4.
- displacement  out  16  rx5.
- status_valid  out  1  one-cycle pulse when status outputs update.
- busy  out  1  frame in progress.
- overrun  out  1  one-cycle pulse when a request is dropped.
- timeout_err  out  1  sticky; cleared by the next successful frame.
- frame_count  out  16  completed frames, wraps 0xFFFF to 0.

Behaviour:
- Reset: all outputs 0, state IDLE, period counter 0, shadow registers 0.
- Period counter:
  - Counts while enable=1; cleared while enable=0.
  - At PERIOD_CYCLES-1 it issues an auto request and wraps to 0.
- Start request = trigger OR auto request.
  - In IDLE: latch pwm_ref and ctrl_flags; clear word index tx_idx and rx_idx; busy=1 on the next cycle; go to LOAD.
  - When busy=1: request dropped, overrun pulses for one cycle, frame continues undisturbed.
- Tx word map:
  - word 0 = HEADER, word 1 = latched pwm_ref, word 2 = latched ctrl_flags.
  - words 3..FRAME_WORDS-1 = 0x0000.
- States:
  - IDLE: busy=0, wren_o=0.
  - LOAD: wait for di_req_i=1. Then register di_o=word[tx_idx], assert wren_o next cycle, go to WRITE.
  - WRITE: hold wren_o and di_o stable until wr_ack_i=1. On the ack cycle, wren_o drops the following cycle and tx_idx increments. Go to WAIT_RX.
  - WAIT_RX: wait for a do_valid_i rising edge (do_valid_i & ~do_valid_q). Store do_i into shadow[rx_idx] and increment rx_idx.
    - If rx_idx was FRAME_WORDS-1, go to DONE.
    - Otherwise go to LOAD.
  - DONE (1 cycle):
    - Copy shadow words 1..5 into position/velocity/current/displacement in the same cycle.
    - status_valid=1, frame_count+1, timeout_err cleared, busy=0 on the next cycle, return to IDLE.
- Receive data:
  - rx word 0 is discarded; the motor board sends a dummy while receiving the header.
  - A do_valid_i edge outside WAIT_RX is ignored.
- Timeout counter:
  - Resets on every state entry; counts in LOAD, WRITE and WAIT_RX.
  - Reaching TIMEOUT_CYCLES forces wren_o=0, sets timeout_err=1, leaves outputs and frame_count unchanged, returns to IDLE.
- Reset mid-frame: immediate return to IDLE with wren_o=0 on the next edge. Shadow contents are discarded.
- Status outputs change only in DONE; partial frames are never visible.
- di_o holds its last value outside WRITE.

Decomposition:
- Shared package myo_pkg holds:
  - the state enum (IDLE, LOAD, WRITE, WAIT_RX, DONE);
  - word-index constants RX_POS_HI=1, RX_POS_LO=2, RX_VEL=3, RX_CUR=4, RX_DISP=5, TX_PWM=1, TX_CTRL=2;
  - the HEADER default.
- One natural sub-module, myo_period_timer: period counter plus auto-request pulse, reusable for other per-motor sequencers.

Test Plan:
- Manual frame, fast-responding SPI master model: trigger with pwm_ref=0x1234, ctrl_flags=0x0003, rx words 0..7 = 0x0000, 0x0001, 0x0002, 0x0010, 0x0020, 0x0030, 0, 0.
  - Expected tx sequence: 0x8000, 0x1234, 0x0003, 0, 0, 0, 0, 0.
  - Expected outputs: one status_valid pulse, position=0x00010002, velocity=0x0010, current=0x0020, displacement=0x0030, frame_count=1.
- Handshake stall: model holds wr_ack_i low for 50 cycles on word 2.
  - wren_o and di_o=0x0003 stay stable throughout; after the ack, wren_o is low on the next cycle.
  - Frame completes; timeout_err=0.
- Periodic mode with PERIOD_CYCLES=200, enable=1 for 1000 cycles, frame takes about 100 cycles: exactly 5 status_valid pulses and frame_count=5.
- Overrun: trigger asserted while busy.
  - overrun pulses once; the frame in progress completes unchanged; no extra frame starts.
- Timeout: model never asserts do_valid_i after word 3.
  - After TIMEOUT_CYCLES: timeout_err=1, busy=0, status outputs unchanged, frame_count unchanged.
  - The next good frame clears timeout_err.
- Reset mid-frame: reset asserted during WRITE of word 4.
  - Next cycle: wren_o=0, busy=0, all outputs 0.
  - A subsequent trigger runs a full correct frame.
